// File: rtl/pump_pkg.sv
// Shared pump PWM definitions: duty limits, counter range, channel states
// and the soft-start ramp arithmetic.
package pump_pkg;

  localparam logic [7:0] PWM_MAX     = 8'd230;
  localparam logic [7:0] PWM_MIN     = 8'd77;
  localparam logic [7:0] PWM_CNT_MAX = 8'd254;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RAMP = 2'd1,
    CH_HOLD = 2'd2
  } ch_state_t;

  // One ramp step toward tgt, clamped at tgt; 9-bit math keeps eff+step and eff-step exact.
  function automatic logic [7:0] ramp_step(input logic [7:0] eff,
                                           input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic [8:0] up_s;
    logic [8:0] dn_s;
    logic [7:0] res_s;
    up_s = {1'b0, eff} + {1'b0, step};
    dn_s = {1'b0, eff} - {1'b0, step};
    if (tgt > eff) begin
      if (up_s >= {1'b0, tgt}) res_s = tgt;
      else                     res_s = up_s[7:0];
    end else if (tgt < eff) begin
      if (dn_s[8] || (dn_s <= {1'b0, tgt})) res_s = tgt;
      else                                  res_s = dn_s[7:0];
    end else begin
      res_s = eff;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/pump_pwm_driver_channel.sv
// One pump PWM channel: target sample, slew-limited effective duty,
// IDLE/RAMP/HOLD state and the registered drive pin.
module pwm_channel
  import pump_pkg::*;
#(
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] tgt,
  input  logic [7:0] cnt,
  input  logic       period_end,
  input  logic       ramp_wrap,
  output logic       pwm_out,
  output logic [7:0] duty_eff,
  output logic       busy
);

  localparam logic [7:0] STEP_C = 8'(RAMP_STEP);

  ch_state_t  state_r;
  ch_state_t  state_nxt_s;
  logic [7:0] eff_r;
  logic [7:0] eff_nxt_s;
  logic [7:0] tgt_r;
  logic [7:0] tgt_nxt_s;
  logic [7:0] samp_tgt_s;
  logic       pin_r;
  logic       busy_r;

  // Next-state, target sample and ramped duty; a zero target or disable wins over any step.
  always_comb begin
    state_nxt_s = state_r;
    eff_nxt_s   = eff_r;
    tgt_nxt_s   = tgt_r;
    samp_tgt_s  = period_end ? tgt : tgt_r;
    if (!enable || (tgt == 8'd0)) begin
      state_nxt_s = CH_IDLE;
      eff_nxt_s   = 8'd0;
      tgt_nxt_s   = 8'd0;
    end else begin
      if (period_end) tgt_nxt_s = tgt;
      else            tgt_nxt_s = tgt_r;
      if (ramp_wrap) eff_nxt_s = ramp_step(eff_r, samp_tgt_s, STEP_C);
      else           eff_nxt_s = eff_r;
      case (state_r)
        CH_IDLE: begin
          if (samp_tgt_s != 8'd0)
            state_nxt_s = (eff_nxt_s == samp_tgt_s) ? CH_HOLD : CH_RAMP;
          else
            state_nxt_s = CH_IDLE;
        end
        CH_RAMP, CH_HOLD: begin
          if (eff_nxt_s == samp_tgt_s) state_nxt_s = CH_HOLD;
          else                         state_nxt_s = CH_RAMP;
        end
        default: state_nxt_s = CH_IDLE;
      endcase
    end
  end

  // State, duty and pin registers; the pin compares against the duty already in force.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= CH_IDLE;
      eff_r   <= 8'd0;
      tgt_r   <= 8'd0;
      pin_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      eff_r   <= eff_nxt_s;
      tgt_r   <= tgt_nxt_s;
      pin_r   <= enable && (cnt < eff_r);
      busy_r  <= (state_nxt_s == CH_RAMP);
    end
  end

  assign pwm_out  = pin_r;
  assign duty_eff = eff_r;
  assign busy     = busy_r;

endmodule

// File: rtl/pump_pwm_driver.sv
// Dual-channel pump PWM stage: shared prescaler, period and ramp counters
// keep pump A and pump B phase-aligned.
module pump_pwm_driver
  import pump_pkg::*;
#(
  parameter int PRESCALE     = 10,
  parameter int RAMP_STEP    = 8,
  parameter int RAMP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] pwm_duty_a,
  input  logic [7:0] pwm_duty_b,
  output logic       pwm_out_a,
  output logic       pwm_out_b,
  output logic [7:0] duty_eff_a,
  output logic [7:0] duty_eff_b,
  output logic       period_start,
  output logic       ramp_busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_PERIODS - 1);

  logic [PW-1:0] presc_r;
  logic [7:0]    cnt_r;
  logic [RW-1:0] ramp_cnt_r;
  logic          period_start_r;
  logic          tick_s;
  logic          period_end_s;
  logic          ramp_wrap_s;
  logic          busy_a_s;
  logic          busy_b_s;

  assign tick_s       = (presc_r == PRESC_LAST);
  assign period_end_s = tick_s && (cnt_r == PWM_CNT_MAX);
  assign ramp_wrap_s  = period_end_s && (ramp_cnt_r == RAMP_LAST);

  // Timebase; disable parks every counter at zero so re-enable starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r        <= '0;
      cnt_r          <= 8'd0;
      ramp_cnt_r     <= '0;
      period_start_r <= 1'b0;
    end else if (!enable) begin
      presc_r        <= '0;
      cnt_r          <= 8'd0;
      ramp_cnt_r     <= '0;
      period_start_r <= 1'b0;
    end else begin
      if (tick_s) presc_r <= '0;
      else        presc_r <= presc_r + PW'(1);
      if (period_end_s) cnt_r <= 8'd0;
      else if (tick_s)  cnt_r <= cnt_r + 8'd1;
      else              cnt_r <= cnt_r;
      if (ramp_wrap_s)       ramp_cnt_r <= '0;
      else if (period_end_s) ramp_cnt_r <= ramp_cnt_r + RW'(1);
      else                   ramp_cnt_r <= ramp_cnt_r;
      period_start_r <= period_end_s;
    end
  end

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_ch_a (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tgt        (pwm_duty_a),
    .cnt        (cnt_r),
    .period_end (period_end_s),
    .ramp_wrap  (ramp_wrap_s),
    .pwm_out    (pwm_out_a),
    .duty_eff   (duty_eff_a),
    .busy       (busy_a_s)
  );

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_ch_b (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tgt        (pwm_duty_b),
    .cnt        (cnt_r),
    .period_end (period_end_s),
    .ramp_wrap  (ramp_wrap_s),
    .pwm_out    (pwm_out_b),
    .duty_eff   (duty_eff_b),
    .busy       (busy_b_s)
  );

  assign period_start = period_start_r;
  assign ramp_busy    = busy_a_s | busy_b_s;

endmodule

// File: tb/tb_pump_pwm_driver.sv
// Randomized self-checking bench for pump_pwm_driver against a per-period
// behavioural model of the two pump channels.
module tb_pump_pwm_driver;

  logic       clk = 1'b0;
  logic       reset, enable, enable2;
  logic [7:0] duty_a, duty_b, duty_a2, duty_b2;
  logic       pwm_out_a, pwm_out_b, period_start, ramp_busy;
  logic [7:0] duty_eff_a, duty_eff_b;
  logic       pwm_out_a2, pwm_out_b2, period_start2, ramp_busy2;
  logic [7:0] duty_eff_a2, duty_eff_b2;

  always #5 clk = ~clk;

  pump_pwm_driver #(.PRESCALE(1), .RAMP_STEP(8), .RAMP_PERIODS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pwm_duty_a(duty_a), .pwm_duty_b(duty_b),
    .pwm_out_a(pwm_out_a), .pwm_out_b(pwm_out_b),
    .duty_eff_a(duty_eff_a), .duty_eff_b(duty_eff_b),
    .period_start(period_start), .ramp_busy(ramp_busy)
  );

  pump_pwm_driver #(.PRESCALE(10), .RAMP_STEP(8), .RAMP_PERIODS(4)) dut10 (
    .clk(clk), .reset(reset), .enable(enable2),
    .pwm_duty_a(duty_a2), .pwm_duty_b(duty_b2),
    .pwm_out_a(pwm_out_a2), .pwm_out_b(pwm_out_b2),
    .duty_eff_a(duty_eff_a2), .duty_eff_b(duty_eff_b2),
    .period_start(period_start2), .ramp_busy(ramp_busy2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase within the 255-count period, effective duty, sampled target, pin, period_start
  int m_cnt;
  int m_eff [2];
  int m_tgt [2];
  int m_pin [2];
  int m_ps;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int approach(input int e, input int t);
    if (t > e)      return (e + 8 > t) ? t : e + 8;
    else if (t < e) return (e - 8 < t) ? t : e - 8;
    else            return e;
  endfunction

  task automatic model_zero();
    m_cnt = 0; m_ps = 0;
    for (int c = 0; c < 2; c++) begin
      m_eff[c] = 0; m_tgt[c] = 0; m_pin[c] = 0;
    end
  endtask

  task automatic check_outputs();
    int busy;
    busy = ((m_tgt[0] != 0 && m_eff[0] != m_tgt[0]) || (m_tgt[1] != 0 && m_eff[1] != m_tgt[1])) ? 1 : 0;
    check_eq("pwm_out_a",    int'(pwm_out_a),    m_pin[0]);
    check_eq("pwm_out_b",    int'(pwm_out_b),    m_pin[1]);
    check_eq("duty_eff_a",   int'(duty_eff_a),   m_eff[0]);
    check_eq("duty_eff_b",   int'(duty_eff_b),   m_eff[1]);
    check_eq("period_start", int'(period_start), m_ps);
    check_eq("ramp_busy",    int'(ramp_busy),    busy);
  endtask

  // advance one clock: model consumes the inputs seen at the edge, then outputs are compared
  task automatic tick(input int n);
    int d [2];
    int pend;
    for (int k = 0; k < n; k++) begin
      d[0] = int'(duty_a); d[1] = int'(duty_b);
      if (reset) begin
        model_zero();
      end else begin
        pend = (enable && m_cnt == 254) ? 1 : 0;
        for (int c = 0; c < 2; c++) m_pin[c] = (enable && m_cnt < m_eff[c]) ? 1 : 0;
        m_ps = pend;
        for (int c = 0; c < 2; c++) begin
          if (!enable || d[c] == 0) begin
            m_eff[c] = 0; m_tgt[c] = 0;
          end else if (pend == 1) begin
            m_tgt[c] = d[c];
            m_eff[c] = approach(m_eff[c], d[c]);
          end
        end
        m_cnt = !enable ? 0 : (pend == 1) ? 0 : m_cnt + 1;
      end
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  task automatic wait_ps(input string tag);
    int seen = 0;
    for (int k = 0; k < 300 && seen == 0; k++) begin
      tick(1);
      if (period_start) seen = 1;
    end
    if (seen == 0) check_eq(tag, 0, 1);
  endtask

  task automatic count_high(input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < 255; k++) begin
      tick(1);
      hi += (ch == 0) ? int'(pwm_out_a) : int'(pwm_out_b);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_pin_a", int'(pwm_out_a), 0);
    check_eq("async_rst_pin_b", int'(pwm_out_b), 0);
    check_eq("async_rst_eff_a", int'(duty_eff_a), 0);
    check_eq("async_rst_busy",  int'(ramp_busy), 0);
    model_zero();
    #1 reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_duty();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0)      return 8'd0;
    else if (r == 1) return 8'd255;
    else             return 8'($urandom_range(1, 254));
  endfunction

  initial begin
    int hi, cyc, last, k;
    reset = 1'b1; enable = 1'b1; duty_a = 8'd230; duty_b = 8'd230;
    enable2 = 1'b0; duty_a2 = 8'd0; duty_b2 = 8'd0;
    model_zero();
    tick(4);
    check_eq("reset_ps10", int'(period_start2), 0);

    // release with zero duty: pins stay low
    reset = 1'b0; duty_a = 8'd0; duty_b = 8'd0;
    tick(10 * 255);

    // soft start 0 -> 230 on A while B ramps to a random level
    duty_a = 8'd230; duty_b = 8'($urandom_range(1, 200));
    tick(31 * 255);
    check_eq("ramp_up_final", int'(duty_eff_a), 230);
    check_eq("ramp_up_busy", int'(ramp_busy), 0);
    wait_ps("ps_timeout_hold");
    count_high(0, hi);
    check_eq("high_clk_230", hi, 230);

    // ramp down to 77, B untouched
    duty_a = 8'd77;
    tick(22 * 255);
    check_eq("ramp_down_final", int'(duty_eff_a), 77);
    check_eq("b_unaffected", int'(duty_eff_b), int'(duty_b));

    // mid-period target change keeps the running period at 77
    wait_ps("ps_timeout_mid");
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == 100) duty_a = 8'd230;
      tick(1);
      hi += int'(pwm_out_a);
    end
    check_eq("mid_period_77", hi, 77);

    // safety override at eff=120
    duty_a = 8'd0;
    tick(2);
    duty_a = 8'd230; duty_b = 8'd255;
    cyc = 0;
    while (duty_eff_a != 8'd120 && cyc < 20 * 255) begin
      tick(1);
      cyc++;
    end
    check_eq("reach_120", int'(duty_eff_a), 120);
    tick(37);
    duty_a = 8'd0;
    tick(1);
    check_eq("override_eff", int'(duty_eff_a), 0);
    tick(1);
    check_eq("override_pin", int'(pwm_out_a), 0);

    // duty 255: pin constantly high
    tick(33 * 255);
    check_eq("eff_b_255", int'(duty_eff_b), 255);
    wait_ps("ps_timeout_255");
    count_high(1, hi);
    check_eq("high_clk_255", hi, 255);

    // enable dropped mid-ramp, then re-enabled
    duty_a = 8'd200;
    tick(5 * 255 + 100);
    enable = 1'b0;
    tick(1);
    check_eq("disable_pin_a", int'(pwm_out_a), 0);
    check_eq("disable_eff_a", int'(duty_eff_a), 0);
    tick(300);
    enable = 1'b1;
    wait_ps("ps_timeout_reen");
    check_eq("reenable_step_a", int'(duty_eff_a), 8);
    check_eq("reenable_step_b", int'(duty_eff_b), 8);

    // random traffic: duty changes, enable toggles, async resets
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      enable = ~enable;
      else if (k == 1) pulse_reset();
      else begin
        duty_a = rand_duty();
        duty_b = rand_duty();
      end
      tick($urandom_range(1, 600));
    end
    enable = 1'b1;

    // PRESCALE=10, RAMP_PERIODS=4 instance: period spacing and ramp cadence
    enable2 = 1'b1; duty_a2 = 8'd100;
    cyc = 0; last = 0; k = 0;
    while (k < 8 && cyc < 30000) begin
      tick(1);
      cyc++;
      if (period_start2) begin
        k++;
        if (k > 1) check_eq("ps_spacing_2550", cyc - last, 2550);
        last = cyc;
        check_eq("eff_every_4", int'(duty_eff_a2), (k / 4) * 8);
      end
    end
    if (k < 8) check_eq("ps10_timeout", k, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
